// File: rtl/scs8hd_polarity_pkg.sv
// rtl/scs8hd_polarity_pkg.sv - shared types and defaults for the polarity-restoring receiver
package scs8hd_polarity_pkg;

  // Receiver modes: searching for the sync word, or assembling payload bytes
  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_e;

  localparam logic [7:0] PRE_DEFAULT    = 8'hD2;
  localparam int         NBYTES_DEFAULT = 4;

endpackage

// File: rtl/scs8hd_polarity_detect.sv
// rtl/scs8hd_polarity_detect.sv - sync-word window and true/inverted comparators
module scs8hd_polarity_detect
  import scs8hd_polarity_pkg::*;
#(
  parameter logic [7:0] PRE = PRE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic clear,
  output logic match_true,
  output logic match_inv
);

  logic [7:0] sreg_q;
  logic [7:0] sreg_d;
  logic [7:0] sreg_shift;

  // Window after this edge's shift; matches look at it so a lock takes effect on the same edge
  always_comb begin
    sreg_shift = {sreg_q[6:0], a};
    match_true = (sreg_shift == PRE);
    match_inv  = (sreg_shift == ~PRE);
    sreg_d     = clear ? 8'h00 : sreg_shift;
  end

  // Window register; clearing at frame end keeps payload tails from aliasing the sync word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= 8'h00;
    end else begin
      sreg_q <= sreg_d;
    end
  end

endmodule

// File: rtl/scs8hd_polarity_rx.sv
// rtl/scs8hd_polarity_rx.sv - serial receiver that detects line polarity from the sync word
module scs8hd_polarity_rx
  import scs8hd_polarity_pkg::*;
#(
  parameter logic [7:0] PRE    = PRE_DEFAULT,
  parameter int         NBYTES = NBYTES_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       A,
  output logic       Y,
  output logic [7:0] DATA,
  output logic       VALID,
  input  logic       READY,
  output logic       INV,
  output logic       LOCKED,
  output logic       OVF
);

  localparam int BCW = $clog2(NBYTES + 1);

  state_e         state_q, state_d;
  logic           inv_q, inv_d;
  logic           y_q, y_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [6:0]     shift_q, shift_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           ovf_q, ovf_d;

  logic           match_true;
  logic           match_inv;
  logic           clear;
  logic           byte_done;
  logic           line_bit;
  logic [7:0]     new_byte;

  scs8hd_polarity_detect #(
    .PRE(PRE)
  ) u_detect (
    .clk       (CLK),
    .rst       (RESET),
    .a         (A),
    .clear     (clear),
    .match_true(match_true),
    .match_inv (match_inv)
  );

  // Next-state: sync lock, payload bit/byte counting, and the single-entry output handshake
  always_comb begin
    state_d   = state_q;
    inv_d     = inv_q;
    bitcnt_d  = bitcnt_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovf_d     = 1'b0;
    clear     = 1'b0;
    byte_done = 1'b0;
    line_bit  = A ^ inv_q;
    new_byte  = {shift_q, line_bit};
    y_d       = A ^ inv_q;

    case (state_q)
      ST_HUNT: begin
        if (match_true) begin
          state_d  = ST_PAYLOAD;
          inv_d    = 1'b0;
          bitcnt_d = 3'd0;
          bcnt_d   = '0;
        end else if (match_inv) begin
          state_d  = ST_PAYLOAD;
          inv_d    = 1'b1;
          bitcnt_d = 3'd0;
          bcnt_d   = '0;
        end
      end
      ST_PAYLOAD: begin
        shift_d  = new_byte[6:0];
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          byte_done = 1'b1;
          if (bcnt_q == BCW'(NBYTES - 1)) begin
            state_d = ST_HUNT;
            bcnt_d  = '0;
            clear   = 1'b1;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase

    // A finished byte either replaces a consumed/empty slot or is dropped with an overflow pulse
    if (byte_done) begin
      if (!valid_q || READY) begin
        data_d  = new_byte;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && READY) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers; reset drops any partial or pending byte silently
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_HUNT;
      inv_q    <= 1'b0;
      y_q      <= 1'b0;
      bitcnt_q <= 3'd0;
      bcnt_q   <= '0;
      shift_q  <= 7'd0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      inv_q    <= inv_d;
      y_q      <= y_d;
      bitcnt_q <= bitcnt_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Y      = y_q;
  assign DATA   = data_q;
  assign VALID  = valid_q;
  assign INV    = inv_q;
  assign LOCKED = (state_q == ST_PAYLOAD);
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_scs8hd_polarity_rx.sv
// tb/tb_scs8hd_polarity_rx.sv - self-checking bench for scs8hd_polarity_rx
module tb_scs8hd_polarity_rx;

  localparam int PRE_V = 8'hD2;
  localparam int NB    = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       A;
  logic       READY;
  logic       Y;
  logic [7:0] DATA;
  logic       VALID;
  logic       INV;
  logic       LOCKED;
  logic       OVF;

  scs8hd_polarity_rx #(.PRE(8'hD2), .NBYTES(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .A     (A),
    .Y     (Y),
    .DATA  (DATA),
    .VALID (VALID),
    .READY (READY),
    .INV   (INV),
    .LOCKED(LOCKED),
    .OVF   (OVF)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Behavioural model: a sliding 8-bit window, a payload bit tally, and a one-slot mailbox
  int m_hunt, m_win, m_inv, m_nbits, m_acc, m_nbytes, m_data, m_valid, m_ovf, m_y;

  logic [7:0] got_q[$];
  int         ovf_cnt;
  int         valid_cycles;
  logic [31:0] y_sh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hunt = 1; m_win = 0; m_inv = 0; m_nbits = 0; m_acc = 0;
    m_nbytes = 0; m_data = 0; m_valid = 0; m_ovf = 0; m_y = 0;
  endtask

  task automatic model_step(input int a, input int rdy);
    int done;
    done  = 0;
    m_y   = a ^ m_inv;
    m_win = ((m_win << 1) | a) & 255;
    if (m_hunt != 0) begin
      if (m_win == PRE_V) begin
        m_hunt = 0; m_inv = 0; m_nbits = 0; m_nbytes = 0;
      end else if (m_win == (~PRE_V & 255)) begin
        m_hunt = 0; m_inv = 1; m_nbits = 0; m_nbytes = 0;
      end
    end else begin
      m_acc   = ((m_acc << 1) | (a ^ m_inv)) & 255;
      m_nbits = m_nbits + 1;
      if (m_nbits % 8 == 0) begin
        done     = 1;
        m_nbytes = m_nbytes + 1;
        if (m_nbytes == NB) begin
          m_hunt = 1; m_win = 0; m_nbits = 0; m_nbytes = 0;
        end
      end
    end
    m_ovf = 0;
    if (done != 0) begin
      if (m_valid == 0 || rdy != 0) begin
        m_data = m_acc; m_valid = 1;
      end else begin
        m_ovf = 1;
      end
    end else if (m_valid != 0 && rdy != 0) begin
      m_valid = 0;
    end
  endtask

  // One line bit: drive, clock, advance the model, then compare every output at the falling edge
  task automatic cycle(input logic a, input logic rdy);
    A     = a;
    READY = rdy;
    if (VALID && rdy) got_q.push_back(DATA);
    @(posedge CLK);
    model_step(int'(a), int'(rdy));
    @(negedge CLK);
    if (OVF) ovf_cnt++;
    if (VALID) valid_cycles++;
    check("outputs", {19'd0, Y, DATA, VALID, INV, LOCKED, OVF},
          {19'd0, m_y[0], m_data[7:0], m_valid[0], m_inv[0], ~m_hunt[0], m_ovf[0]});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] rdy, input bit ycap);
    for (int i = 7; i >= 0; i--) begin
      cycle(b[i], rdy[i]);
      if (ycap) y_sh = {y_sh[30:0], Y};
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1);
  endtask

  function automatic logic [31:0] pack4();
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < got_q.size() && i < 4; i++) r = {r[23:0], got_q[i]};
    return r;
  endfunction

  task automatic start_test();
    got_q.delete();
    ovf_cnt      = 0;
    valid_cycles = 0;
    y_sh         = 32'd0;
  endtask

  initial begin
    RESET = 1'b1;
    A     = 1'b0;
    READY = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_state", {19'd0, Y, DATA, VALID, INV, LOCKED, OVF}, 32'd0);
    RESET = 1'b0;

    // True polarity frame
    start_test();
    send_byte(8'hD2, 8'hFF, 1'b0);
    check("t1_locked", {31'd0, LOCKED}, 32'd1);
    send_byte(8'h11, 8'hFF, 1'b0);
    send_byte(8'h22, 8'hFF, 1'b0);
    send_byte(8'h33, 8'hFF, 1'b0);
    check("t1_locked_mid", {31'd0, LOCKED}, 32'd1);
    send_byte(8'h44, 8'hFF, 1'b0);
    check("t1_locked_end", {31'd0, LOCKED}, 32'd0);
    idle(4);
    check("t1_bytes", pack4(), 32'h11223344);
    check("t1_count", got_q.size(), 32'd4);
    check("t1_valid_cycles", valid_cycles, 32'd4);
    check("t1_inv", {31'd0, INV}, 32'd0);

    // Inverted polarity frame
    start_test();
    send_byte(8'h2D, 8'hFF, 1'b0);
    check("t2_inv", {31'd0, INV}, 32'd1);
    send_byte(8'hEE, 8'hFF, 1'b1);
    send_byte(8'hDD, 8'hFF, 1'b1);
    send_byte(8'hCC, 8'hFF, 1'b1);
    send_byte(8'hBB, 8'hFF, 1'b1);
    idle(4);
    check("t2_bytes", pack4(), 32'h11223344);
    check("t2_y_stream", y_sh, 32'h11223344);
    check("t2_inv_hold", {31'd0, INV}, 32'd1);

    // Consumer stalled for the whole frame
    start_test();
    send_byte(8'hD2, 8'h00, 1'b0);
    send_byte(8'hAA, 8'h00, 1'b0);
    send_byte(8'h55, 8'h00, 1'b0);
    send_byte(8'h0F, 8'h00, 1'b0);
    send_byte(8'hF0, 8'h00, 1'b0);
    check("t3_data", {24'd0, DATA}, 32'hAA);
    check("t3_valid", {31'd0, VALID}, 32'd1);
    check("t3_ovf", ovf_cnt, 32'd3);
    check("t3_inv", {31'd0, INV}, 32'd0);
    idle(3);
    check("t3_drain", got_q.size(), 32'd1);
    check("t3_byte", {24'd0, got_q[0]}, 32'hAA);

    // Completion coinciding with a consume
    start_test();
    send_byte(8'hD2, 8'h00, 1'b0);
    send_byte(8'h11, 8'h00, 1'b0);
    send_byte(8'h22, 8'h01, 1'b0);
    check("t4_data", {24'd0, DATA}, 32'h22);
    check("t4_valid", {31'd0, VALID}, 32'd1);
    send_byte(8'h33, 8'hFF, 1'b0);
    send_byte(8'h44, 8'hFF, 1'b0);
    idle(3);
    check("t4_ovf", ovf_cnt, 32'd0);
    check("t4_bytes", pack4(), 32'h11223344);

    // Reset mid-frame with a pending byte
    start_test();
    send_byte(8'hD2, 8'hFF, 1'b0);
    send_byte(8'hAB, 8'h00, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    RESET = 1'b1;
    #1;
    check("t5_async_reset", {19'd0, Y, DATA, VALID, INV, LOCKED, OVF}, 32'd0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    check("t5_reset_hold", {19'd0, Y, DATA, VALID, INV, LOCKED, OVF}, 32'd0);
    RESET = 1'b0;
    start_test();
    send_byte(8'hD2, 8'hFF, 1'b0);
    send_byte(8'h55, 8'hFF, 1'b0);
    send_byte(8'h66, 8'hFF, 1'b0);
    send_byte(8'h77, 8'hFF, 1'b0);
    send_byte(8'h88, 8'hFF, 1'b0);
    idle(3);
    check("t5_bytes", pack4(), 32'h55667788);
    check("t5_ovf", ovf_cnt, 32'd0);

    // Payload that looks like the sync word, then idle line
    start_test();
    for (int k = 0; k < 5; k++) send_byte(8'hD2, 8'hFF, 1'b0);
    idle(16);
    check("t6_count", got_q.size(), 32'd4);
    check("t6_bytes", pack4(), 32'hD2D2D2D2);
    check("t6_no_relock", {31'd0, LOCKED}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/scs8hd_polarity_rx.md
SCS8HD_POLARITY_RX -- requirements
Module: scs8hd_polarity_rx

Interface
REQ-001 The module SHALL have parameter PRE, default 8'hD2, meaning the sync word in true polarity.
REQ-002 The module SHALL have parameter NBYTES, default 4, meaning payload bytes per frame; legal range 1..255.
REQ-003 Port CLK, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port RESET, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-005 Port A, input, 1 bit, SHALL be the serial line, synchronous to CLK, one bit per cycle, MSB first, possibly inverted by an unknown number of bufinv stages.
REQ-006 Port Y, output, 1 bit, SHALL be the registered polarity-restored line bit: A XOR INV.
REQ-007 Port DATA, output, 8 bits, SHALL be the restored payload byte.
REQ-008 Port VALID, output, 1 bit, SHALL indicate DATA holds an unconsumed byte.
REQ-009 Port READY, input, 1 bit, SHALL indicate the consumer accepts DATA this cycle.
REQ-010 Port INV, output, 1 bit, SHALL be the detected line polarity (1 = inverted).
REQ-011 Port LOCKED, output, 1 bit, SHALL be high while the FSM is in PAYLOAD.
REQ-012 Port OVF, output, 1 bit, SHALL pulse for one cycle when a completed byte is dropped.

Function
REQ-013 The FSM SHALL have two states: HUNT and PAYLOAD.
REQ-014 In every state, an 8-bit shift register SHALL shift in A on each edge: sreg_next = {sreg[6:0], A}.
REQ-015 In HUNT, if sreg_next == PRE, the FSM SHALL go to PAYLOAD with INV=0 on that same edge.
REQ-016 In HUNT, if sreg_next == ~PRE, the FSM SHALL go to PAYLOAD with INV=1 on that same edge.
REQ-017 INV SHALL change only on a HUNT->PAYLOAD transition and SHALL hold through the frame and the following HUNT.
REQ-018 In PAYLOAD, the first payload bit SHALL be the A sampled on the edge after the sync-detect edge.
REQ-019 Each payload bit SHALL be XORed with INV before being placed in the byte assembler.
REQ-020 A 3-bit bit counter SHALL wrap 7->0; a byte completes on the edge sampling bit 7.
REQ-021 On byte completion with VALID=0, or with VALID=1 and READY=1, DATA SHALL load the byte and VALID SHALL be 1 after that edge.
REQ-022 On byte completion with VALID=1 and READY=0, DATA and VALID SHALL hold, the new byte SHALL be dropped, and OVF SHALL be 1 for exactly that cycle.
REQ-023 Without a byte completion, VALID=1 and READY=1 SHALL clear VALID at the edge; READY with VALID=0 SHALL have no effect.
REQ-024 A byte counter SHALL count completed bytes, including dropped ones.
REQ-025 On the edge completing byte NBYTES, the FSM SHALL return to HUNT and clear sreg to 8'h00, so payload tails cannot match PRE.
REQ-026 Y SHALL be updated every cycle in all states, with latency 1 cycle from A.
REQ-027 The VALID/DATA handshake SHALL continue normally in HUNT until the last byte is consumed.

Reset
REQ-028 While RESET=1, the state SHALL be HUNT, with sreg, counters, DATA=8'h00, and Y, VALID, INV, LOCKED, OVF all 0.
REQ-029 Assertion mid-frame SHALL discard any partial byte and any pending VALID byte, without generating OVF.
REQ-030 After RESET deasserts, hunting SHALL restart with the first edge.

Structure
REQ-031 Package scs8hd_polarity_pkg SHALL hold the state enum, the PRE default (8'hD2) and the NBYTES default (4).
REQ-032 One sub-module, scs8hd_polarity_detect, SHALL hold the shift register and the PRE/~PRE comparators, and output match_true and match_inv.
REQ-033 The byte counter width SHALL be $clog2(NBYTES+1).

Verification
REQ-034 True line: A = D2 then 11 22 33 44 (MSB first), READY=1 -> INV=0; DATA 11,22,33,44 each with one VALID cycle; LOCKED falls after the 44 byte.
REQ-035 Inverted line: A = 2D then EE DD CC BB -> INV=1; DATA 11,22,33,44; Y equals the true-polarity stream delayed 1 cycle.
REQ-036 READY=0 for the whole frame D2 AA 55 0F F0 -> DATA=AA held with VALID=1; OVF pulses 3 times (for 55, 0F, F0).
REQ-037 Byte completes with VALID=1 and READY=1 in the same cycle -> no OVF; DATA updates to the new byte; VALID stays 1.
REQ-038 RESET pulse after 12 payload bits -> all outputs 0; no VALID; a subsequent D2 frame is received correctly.
REQ-039 Payload containing D2 (D2 D2 D2 D2 D2), then idle 00 -> exactly 4 bytes of D2; no relock until a new sync word arrives.
